// File: rtl/board_input_port_pkg.sv
// Shared constants for the board input port: register offsets and pin counts.
package board_io_pkg;

  typedef logic [1:0] reg_off_t;

  localparam reg_off_t OFF_SWITCH = 2'd0;
  localparam reg_off_t OFF_LEVEL  = 2'd1;
  localparam reg_off_t OFF_PRESS  = 2'd2;
  localparam reg_off_t OFF_COUNT  = 2'd3;

  localparam int NUM_KEYS = 3;
  localparam int NUM_SW   = 10;

endpackage

// File: rtl/board_input_port_if.sv
// Processor read bus into the board input port register window.
interface board_input_port_if;
  import board_io_pkg::*;

  logic [31:0] readadr;
  logic        re;
  logic [31:0] rdata;

  modport master (output readadr, output re, input rdata);
  modport slave  (input readadr, input re, output rdata);

endinterface

// File: rtl/board_input_port_debounce.sv
// One push button: 2-flop synchronizer, stability counter and rising-edge press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_p0, key_p1;
  logic [CW-1:0] cnt;
  logic          differ, expire;

  assign differ = (key_p1 != level);
  assign expire = differ && (cnt == CNT_LAST);
  assign press  = expire && !level && !reset;

  // The synchronizer carries the pressed polarity so its reset value reads as released.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      key_p0 <= ~raw;
      key_p1 <= key_p0;
      if (!differ) begin
        cnt <= '0;
      end else if (expire) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_port.sv
// DE0 switch/button register window: synced switches, debounced keys, sticky press flags, press counter.
module board_input_port
  import board_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_FF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] KEY,
  board_input_port_if.slave   bus
);

  logic [NUM_SW-1:0]   sw_p0, sw_p1;
  logic [NUM_KEYS-1:0] level, press, press_flags;
  logic [15:0]         press_count;
  logic                hit, rd_clear, unused_lsb;
  reg_off_t            offset;
  logic [31:0]         rdata_c;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (KEY[k]),
      .level (level[k]),
      .press (press[k])
    );
  end

  assign hit        = (bus.readadr[31:4] == BASE_ADDR[31:4]);
  assign offset     = bus.readadr[3:2];
  assign rd_clear   = bus.re && hit && (offset == OFF_PRESS);
  assign unused_lsb = ^bus.readadr[1:0];

  // A press in the same cycle as a read-clear survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p0       <= '0;
      sw_p1       <= '0;
      press_flags <= '0;
      press_count <= '0;
    end else begin
      sw_p0       <= SW;
      sw_p1       <= sw_p0;
      press_flags <= (rd_clear ? '0 : press_flags) | press;
      if (|press) press_count <= press_count + 16'd1;
    end
  end

  always_comb begin
    rdata_c = '0;
    if (hit) begin
      case (offset)
        OFF_SWITCH: rdata_c = {22'b0, sw_p1};
        OFF_LEVEL:  rdata_c = {29'b0, level};
        OFF_PRESS:  rdata_c = {29'b0, press_flags};
        OFF_COUNT:  rdata_c = {16'b0, press_count};
      endcase
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_board_input_port.sv
// Bench for board_input_port: vector table, directed key sequences, randomized run against a model.
module tb_board_input_port;
  import board_io_pkg::*;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] SW;
  logic [2:0] KEY;

  board_input_port_if bus();

  board_input_port #(.DEBOUNCE_CYCLES(D), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .KEY   (KEY),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: two-cycle delayed copies, disagreement run lengths.
  logic [9:0] m_sw1, m_sw2;
  logic [2:0] m_k1, m_k2, m_lvl, m_flags;
  int         m_run[3];
  int         m_cnt;

  task automatic model_step();
    logic [2:0] pulses;
    logic       clear;
    if (reset) begin
      m_sw1 = '0; m_sw2 = '0; m_k1 = '0; m_k2 = '0;
      m_lvl = '0; m_flags = '0; m_cnt = 0;
      for (int k = 0; k < 3; k++) m_run[k] = 0;
    end else begin
      pulses = '0;
      clear  = bus.re && (bus.readadr[31:4] == BASE[31:4]) && (bus.readadr[3:2] == 2'd2);
      for (int k = 0; k < 3; k++) begin
        if (m_k2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            pulses[k] = ~m_lvl[k];
            m_lvl[k]  = ~m_lvl[k];
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_flags = (clear ? 3'b000 : m_flags) | pulses;
      if (pulses != 3'b000) m_cnt = (m_cnt + 1) % 65536;
      m_k2 = m_k1; m_k1 = ~KEY;
      m_sw2 = m_sw1; m_sw1 = SW;
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0:    r = {22'b0, m_sw2};
        2'd1:    r = {29'b0, m_lvl};
        2'd2:    r = {29'b0, m_flags};
        default: r = {16'b0, 16'(m_cnt)};
      endcase
    end
    return r;
  endfunction

  task automatic cycle(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.readadr = a;
    #1;
    chk(nm, bus.rdata, exp);
  endtask

  typedef struct {
    logic [9:0]  sw;
    logic [31:0] adr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{10'h2A5, 32'h0000_FF00, 32'h0000_02A5};
    tbl[1] = '{10'h2A5, 32'h0000_FF03, 32'h0000_02A5};
    tbl[2] = '{10'h2A5, 32'h0000_FF04, 32'h0000_0000};
    tbl[3] = '{10'h2A5, 32'h0000_FF10, 32'h0000_0000};
    tbl[4] = '{10'h3FF, 32'h0000_FF01, 32'h0000_03FF};
    tbl[5] = '{10'h3FF, 32'h1000_FF00, 32'h0000_0000};
    tbl[6] = '{10'h155, 32'h0000_FF02, 32'h0000_0155};
    tbl[7] = '{10'h155, 32'h0000_FF0C, 32'h0000_0000};
    tbl[8] = '{10'h000, 32'h0000_FF00, 32'h0000_0000};

    reset = 1'b1; KEY = 3'b111; SW = '0; bus.re = 1'b0; bus.readadr = BASE;
    cycle(3);
    rd("rst_switch", 32'hFF00, 32'h0);
    rd("rst_level",  32'hFF04, 32'h0);
    rd("rst_press",  32'hFF08, 32'h0);
    rd("rst_count",  32'hFF0C, 32'h0);
    reset = 1'b0;
    cycle(3);

    for (int i = 0; i < 9; i++) begin
      SW = tbl[i].sw;
      cycle(3);
      rd($sformatf("vec%0d", i), tbl[i].adr, tbl[i].exp);
    end

    // Short bounces on KEY[0] never register.
    repeat (3) begin
      KEY = 3'b110; cycle(2);
      KEY = 3'b111; cycle(3);
    end
    cycle(6);
    rd("bounce_level", 32'hFF04, 32'h0);
    rd("bounce_press", 32'hFF08, 32'h0);
    rd("bounce_count", 32'hFF0C, 32'h0);

    // KEY[1] held, then read-clear of PRESS.
    KEY = 3'b101;
    cycle(10);
    rd("k1_level", 32'hFF04, 32'h2);
    rd("k1_press", 32'hFF08, 32'h2);
    rd("k1_count", 32'hFF0C, 32'h1);
    bus.re = 1'b1;
    rd("k1_clear_read", 32'hFF08, 32'h2);
    cycle(1);
    bus.re = 1'b0;
    rd("k1_press_after", 32'hFF08, 32'h0);
    rd("k1_level_after", 32'hFF04, 32'h2);
    KEY = 3'b111;
    cycle(10);
    rd("k1_rel_level", 32'hFF04, 32'h0);
    rd("k1_rel_press", 32'hFF08, 32'h0);
    rd("k1_rel_count", 32'hFF0C, 32'h1);

    // Set flag 0, then align KEY[2] pulse with a read-clear.
    KEY = 3'b110; cycle(10);
    KEY = 3'b111; cycle(10);
    rd("f0_press", 32'hFF08, 32'h1);
    KEY = 3'b011;
    cycle(5);
    bus.re = 1'b1;
    rd("clr_pulse_read", 32'hFF08, 32'h1);
    cycle(1);
    bus.re = 1'b0;
    rd("clr_pulse_press", 32'hFF08, 32'h4);
    rd("clr_pulse_level", 32'hFF04, 32'h4);
    rd("clr_pulse_count", 32'hFF0C, 32'h3);
    KEY = 3'b111;
    cycle(10);

    // Counter wrap via preload.
    force dut.press_count = 16'hFFFF;
    #1;
    release dut.press_count;
    m_cnt = 65535;
    rd("wrap_pre", 32'hFF0C, 32'h0000_FFFF);
    KEY = 3'b101;
    cycle(8);
    rd("wrap_count", 32'hFF0C, 32'h0);
    KEY = 3'b111;
    cycle(10);

    // Reset in the middle of a KEY[0] hold.
    KEY = 3'b110;
    cycle(2);
    reset = 1'b1;
    cycle(1);
    rd("mid_rst_press", 32'hFF08, 32'h0);
    rd("mid_rst_level", 32'hFF04, 32'h0);
    cycle(1);
    rd("mid_rst_press2", 32'hFF08, 32'h0);
    reset = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      cycle(1);
      rd($sformatf("post_rst_level%0d", r), 32'hFF04, (r == 6) ? 32'h1 : 32'h0);
      rd($sformatf("post_rst_press%0d", r), 32'hFF08, (r == 6) ? 32'h1 : 32'h0);
    end
    KEY = 3'b111;
    cycle(10);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int sel;
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 7) == 0) KEY[k] = ~KEY[k];
      if ($urandom_range(0, 15) == 0) SW = 10'($urandom());
      reset  = ($urandom_range(0, 127) == 0);
      bus.re = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1, 2, 3: bus.readadr = BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
        4:          bus.readadr = BASE + 32'($urandom_range(0, 15));
        5:          bus.readadr = 32'h0000_FE08;
        6:          bus.readadr = $urandom();
        default:    bus.readadr = BASE | 32'h8;
      endcase
      #1;
      chk($sformatf("rand%0d", n), bus.rdata, m_rd(bus.readadr));
      cycle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
